// File: rtl/hr_spo2_pkg.sv
// Shared constants, state encoding and measurement payload for the HR/SpO2 frame parser.
package hr_spo2_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 52000;
    localparam int unsigned TO_W_DEF        = 16;

    localparam logic [BYTE_W-1:0] HDR0_DEF     = 8'hAA;
    localparam logic [BYTE_W-1:0] HDR1_DEF     = 8'h55;
    localparam logic [BYTE_W-1:0] SPO2_MAX_DEF = 8'd100;
    localparam logic [BYTE_W-1:0] ERR_CNT_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_H1   = 3'd1,
        S_HR   = 3'd2,
        S_SP   = 3'd3,
        S_CK   = 3'd4
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] hr;
        logic [BYTE_W-1:0] spo2;
    } meas_t;

    // 8-bit wrapping checksum carried in the last byte of a frame.
    function automatic logic [BYTE_W-1:0] frame_chk(input logic [BYTE_W-1:0] hr,
                                                    input logic [BYTE_W-1:0] spo2);
        return BYTE_W'(hr + spo2);
    endfunction

endpackage

// File: rtl/rx_timeout_cnt.sv
// Inter-byte idle counter; pulses expire_c for one cycle when the idle limit is reached.
module rx_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 52000,
    parameter int unsigned TO_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Held at the limit so a stalled enable cannot wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A byte arriving on the expiry cycle suppresses the pulse.
    assign expire_c = en && !clr && (cnt_q == LIMIT);

endmodule

// File: rtl/hr_spo2_frame_parser.sv
// Assembles AA 55 HR SPO2 CHK frames from the UART byte stream and publishes validated readings.
module hr_spo2_frame_parser
    import hr_spo2_pkg::*;
#(
    parameter logic [7:0]  HDR0        = HDR0_DEF,
    parameter logic [7:0]  HDR1        = HDR1_DEF,
    parameter logic [7:0]  SPO2_MAX    = SPO2_MAX_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned TO_W        = TO_W_DEF
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] Rx_Data,
    input  logic       Rx_Valid,
    input  logic       Clr_Err,
    output logic [7:0] Hr,
    output logic [7:0] Spo2,
    output logic       Meas_Valid,
    output logic       Frame_Err,
    output logic [7:0] Err_Cnt,
    output logic       Busy
);

    state_e     state_q,      state_d;
    logic [7:0] hr_tmp_q,     hr_tmp_d;
    logic [7:0] sp_tmp_q,     sp_tmp_d;
    meas_t      meas_q,       meas_d;
    logic       meas_valid_q, meas_valid_d;
    logic       frame_err_q,  frame_err_d;
    logic [7:0] err_cnt_q,    err_cnt_d;
    logic       busy_q,       busy_d;
    logic       timeout_c;

    rx_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timeout (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .clr      (Rx_Valid),
        .en       (state_q != S_IDLE),
        .expire_c (timeout_c)
    );

    // Frame state machine plus checksum/range validation on the CHK byte.
    always_comb begin
        state_d      = state_q;
        hr_tmp_d     = hr_tmp_q;
        sp_tmp_d     = sp_tmp_q;
        meas_d       = meas_q;
        meas_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (Rx_Valid) begin
            case (state_q)
                S_IDLE: begin
                    if (Rx_Data == HDR0) begin
                        state_d = S_H1;
                    end
                end
                S_H1: begin
                    if (Rx_Data == HDR1) begin
                        state_d = S_HR;
                    end else if (Rx_Data == HDR0) begin
                        state_d = S_H1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HR: begin
                    hr_tmp_d = Rx_Data;
                    state_d  = S_SP;
                end
                S_SP: begin
                    sp_tmp_d = Rx_Data;
                    state_d  = S_CK;
                end
                S_CK: begin
                    state_d = S_IDLE;
                    if ((Rx_Data == frame_chk(hr_tmp_q, sp_tmp_q)) && (sp_tmp_q <= SPO2_MAX)) begin
                        meas_d.hr    = hr_tmp_q;
                        meas_d.spo2  = sp_tmp_q;
                        meas_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (timeout_c) begin
            // A lone header byte timing out is just line noise, not a broken frame.
            state_d     = S_IDLE;
            frame_err_d = (state_q != S_H1);
        end
    end

    // Saturating error counter; clear takes priority over a coincident error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (Clr_Err) begin
            err_cnt_d = '0;
        end else if (frame_err_d && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            hr_tmp_q     <= '0;
            sp_tmp_q     <= '0;
            meas_q       <= '0;
            meas_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hr_tmp_q     <= hr_tmp_d;
            sp_tmp_q     <= sp_tmp_d;
            meas_q       <= meas_d;
            meas_valid_q <= meas_valid_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign Hr         = meas_q.hr;
    assign Spo2       = meas_q.spo2;
    assign Meas_Valid = meas_valid_q;
    assign Frame_Err  = frame_err_q;
    assign Err_Cnt    = err_cnt_q;
    assign Busy       = busy_q;

endmodule
